// File: rtl/xadc_drp_scanner.sv
// Periodic read-only DRP scanner: each tick, read every enabled XADC slot once, one DRP read in flight at a time.
// den_out to result_valid takes (drdy delay)+2 cycles; busy_in stalls issue; unanswered reads are abandoned after TIMEOUT wait cycles.
module xadc_drp_scanner #(
    parameter int TICK_DIV = 100000,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [27:0] ch_addr_list,
    input  logic [3:0]  ch_enable,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    input  logic [15:0] do_in,
    input  logic        drdy_in,
    input  logic        busy_in,
    output logic [11:0] result_data,
    output logic [1:0]  result_slot,
    output logic        result_valid,
    output logic        scan_done,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    en_q, en_d;
    logic [6:0]    daddr_q, daddr_d;
    logic          den_q, den_d;
    logic [11:0]   rdata_q, rdata_d;
    logic [1:0]    rslot_q, rslot_d;
    logic          rvld_q, rvld_d;
    logic          done_q, done_d;
    logic          tmo_q, tmo_d;
    logic          ovr_q, ovr_d;

    logic          tick;
    logic [4:0]    addr_base;
    logic [3:0]    above;
    logic          unused_do_lsbs;

    assign unused_do_lsbs = ^do_in[3:0];
    assign tick           = (cnt_q == CW'(TICK_DIV - 1));

    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) first_set = 2'(i);
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        tcnt_d    = tcnt_q;
        idx_d     = idx_q;
        en_d      = en_q;
        daddr_d   = daddr_q;
        den_d     = 1'b0;
        rdata_d   = rdata_q;
        rslot_d   = rslot_q;
        rvld_d    = 1'b0;
        done_d    = 1'b0;
        tmo_d     = tmo_q;
        // A tick landing mid-scan is only flagged; the scan never restarts from it.
        ovr_d     = ovr_q | (tick & (state_q != ST_IDLE));
        addr_base = 5'(idx_q) * 5'd7;
        above     = en_q & (4'b1110 << idx_q);

        case (state_q)
            ST_IDLE: begin
                if (tick && (ch_enable != 4'd0)) begin
                    en_d    = ch_enable;
                    idx_d   = first_set(ch_enable);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!busy_in) begin
                    den_d   = 1'b1;
                    daddr_d = ch_addr_list[addr_base +: 7];
                    tcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // drdy wins over a timeout expiring in the same cycle.
                if (drdy_in) begin
                    rdata_d = do_in[15:4];
                    rslot_d = idx_q;
                    state_d = ST_STORE;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
            end
            ST_STORE: begin
                rvld_d  = 1'b1;
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (above != 4'd0) begin
                    idx_d   = first_set(above);
                    state_d = ST_ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= 2'd0;
            en_q    <= 4'd0;
            daddr_q <= 7'd0;
            den_q   <= 1'b0;
            rdata_q <= 12'd0;
            rslot_q <= 2'd0;
            rvld_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            daddr_q <= daddr_d;
            den_q   <= den_d;
            rdata_q <= rdata_d;
            rslot_q <= rslot_d;
            rvld_q  <= rvld_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
        end
    end

    assign daddr_out    = daddr_q;
    assign den_out      = den_q;
    assign dwe_out      = 1'b0;
    assign result_data  = rdata_q;
    assign result_slot  = rslot_q;
    assign result_valid = rvld_q;
    assign scan_done    = done_q;
    assign timeout_err  = tmo_q;
    assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Directed bench for xadc_drp_scanner with TICK_DIV=100, TIMEOUT=255; every check is an immediate assertion.
module tb_xadc_drp_scanner;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic [27:0] ch_addr_list;
    logic [3:0]  ch_enable;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] do_in;
    logic        drdy_in;
    logic        busy_in;
    logic [11:0] result_data;
    logic [1:0]  result_slot;
    logic        result_valid;
    logic        scan_done;
    logic        timeout_err;
    logic        overrun_err;

    always #5 CLK100MHZ = ~CLK100MHZ;

    xadc_drp_scanner #(.TICK_DIV(100), .TIMEOUT(255)) dut (
        .CLK100MHZ    (CLK100MHZ),
        .reset        (reset),
        .ch_addr_list (ch_addr_list),
        .ch_enable    (ch_enable),
        .daddr_out    (daddr_out),
        .den_out      (den_out),
        .dwe_out      (dwe_out),
        .do_in        (do_in),
        .drdy_in      (drdy_in),
        .busy_in      (busy_in),
        .result_data  (result_data),
        .result_slot  (result_slot),
        .result_valid (result_valid),
        .scan_done    (scan_done),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err)
    );

    int cyc = 0;
    int den_cnt = 0, rv_cnt = 0, sd_cnt = 0;
    int n_checks = 0, n_fail = 0;

    // cyc equals the number of rising edges seen; stable when read on falling edges.
    always @(posedge CLK100MHZ) begin
        cyc <= cyc + 1;
        if (den_out === 1'b1)      den_cnt <= den_cnt + 1;
        if (result_valid === 1'b1) rv_cnt  <= rv_cnt + 1;
        if (scan_done === 1'b1)    sd_cnt  <= sd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge CLK100MHZ);
    endtask

    task automatic wait_den(output int dc);
        dc = -1;
        for (int i = 0; i < 400 && dc < 0; i++) begin
            @(negedge CLK100MHZ);
            if (den_out === 1'b1) dc = cyc;
        end
        check("den_seen", (dc >= 0), 1);
    endtask

    // Answers one DRP read k cycles after den and checks the result strobe lands k+2 cycles after den.
    task automatic read_txn(input int k, input logic [15:0] dat, input logic [6:0] exp_addr,
                            input logic [1:0] exp_slot, input int exp_den_cyc, input string tag);
        int dc;
        wait_den(dc);
        if (dc < 0) return;
        check({tag, "_den_cycle"}, dc, exp_den_cyc);
        check({tag, "_addr"}, daddr_out, exp_addr);
        check({tag, "_dwe"}, dwe_out, 0);
        @(negedge CLK100MHZ);
        check({tag, "_den_single"}, den_out, 0);
        repeat (k - 1) @(negedge CLK100MHZ);
        drdy_in = 1'b1;
        do_in   = dat;
        @(negedge CLK100MHZ);
        drdy_in = 1'b0;
        do_in   = 16'h5555;
        @(negedge CLK100MHZ);
        check({tag, "_rv"}, result_valid, 1);
        check({tag, "_slot"}, result_slot, exp_slot);
        check({tag, "_data"}, result_data, {20'd0, dat[15:4]});
        check({tag, "_addr_hold"}, daddr_out, exp_addr);
        @(negedge CLK100MHZ);
        check({tag, "_rv_single"}, result_valid, 0);
    endtask

    initial begin
        int dc;
        int snap_den, snap_rv, snap_sd;
        bit any_den;

        ch_addr_list = {7'h05, 7'h7F, 7'h11, 7'h1B};
        ch_enable    = 4'b0101;
        do_in        = 16'h0000;
        drdy_in      = 1'b0;
        busy_in      = 1'b0;

        tick_to(3);
        check("rst_daddr", daddr_out, 0);
        check("rst_den", den_out, 0);
        check("rst_dwe", dwe_out, 0);
        check("rst_rdata", result_data, 0);
        check("rst_rslot", result_slot, 0);
        check("rst_rv", result_valid, 0);
        check("rst_done", scan_done, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_ovr", overrun_err, 0);
        reset = 1'b0;

        // Scan 1: slots 0 and 2; slot 2 address and ch_enable change after the scan starts.
        read_txn(3, 16'hFFF0, 7'h1B, 2'd0, 104, "s0");
        ch_addr_list = {7'h05, 7'h13, 7'h11, 7'h1B};
        ch_enable    = 4'b0010;
        read_txn(3, 16'h0008, 7'h13, 2'd2, 111, "s2");
        check("scan1_done", scan_done, 1);
        @(negedge CLK100MHZ);
        check("scan1_done_single", scan_done, 0);
        check("scan1_ovr", overrun_err, 0);

        // No enabled slots: the tick at cycle 202 must start nothing.
        tick_to(150);
        ch_enable = 4'b0000;
        snap_den  = den_cnt;
        snap_sd   = sd_cnt;
        tick_to(250);
        check("empty_no_den", den_cnt - snap_den, 0);
        check("empty_no_done", sd_cnt - snap_sd, 0);

        // busy_in holds ISSUE (cycles 303..312); den on the first cycle busy_in is low.
        ch_enable = 4'b1000;
        busy_in   = 1'b1;
        tick_to(300);
        any_den = 1'b0;
        while (cyc < 313) begin
            @(negedge CLK100MHZ);
            if (den_out !== 1'b0) any_den = 1'b1;
        end
        check("busy_no_den", any_den, 0);
        busy_in = 1'b0;
        read_txn(1, 16'h1230, 7'h05, 2'd3, 314, "busy");
        check("busy_done", scan_done, 1);

        // Reply delayed 150 cycles: tick at 502 overruns and is dropped.
        tick_to(350);
        ch_enable = 4'b0001;
        snap_den  = den_cnt;
        snap_sd   = sd_cnt;
        read_txn(150, 16'h4560, 7'h1B, 2'd0, 404, "ovr");
        check("ovr_done", scan_done, 1);
        check("ovr_flag", overrun_err, 1);
        check("ovr_no_tmo", timeout_err, 0);
        tick_to(600);
        check("ovr_one_den", den_cnt - snap_den, 1);
        check("ovr_one_done", sd_cnt - snap_sd, 1);

        // Slot 0 never answers: abandoned after 255 wait cycles, slot 1 still read.
        ch_enable = 4'b0011;
        snap_rv   = rv_cnt;
        wait_den(dc);
        check("tmo_den_cycle", dc, 604);
        check("tmo_addr", daddr_out, 7'h1B);
        tick_to(859);
        check("tmo_not_yet", timeout_err, 0);
        tick_to(860);
        check("tmo_set", timeout_err, 1);
        check("tmo_no_rv", rv_cnt - snap_rv, 0);
        check("tmo_data_kept", result_data, 12'h456);
        read_txn(2, 16'hABC0, 7'h11, 2'd1, 862, "tmo_s1");
        check("tmo_done", scan_done, 1);
        check("tmo_sticky", timeout_err, 1);

        // Reset in WAIT, then a stray drdy: nothing may come out until the next tick.
        tick_to(880);
        ch_enable = 4'b0001;
        wait_den(dc);
        check("rw_den_cycle", dc, 904);
        tick_to(905);
        reset = 1'b1;
        tick_to(907);
        reset = 1'b0;
        check("rw_daddr", daddr_out, 0);
        check("rw_den", den_out, 0);
        check("rw_rdata", result_data, 0);
        check("rw_rslot", result_slot, 0);
        check("rw_rv", result_valid, 0);
        check("rw_done", scan_done, 0);
        check("rw_tmo", timeout_err, 0);
        check("rw_ovr", overrun_err, 0);
        snap_rv  = rv_cnt;
        snap_den = den_cnt;
        tick_to(908);
        drdy_in = 1'b1;
        do_in   = 16'hFFF0;
        tick_to(909);
        drdy_in = 1'b0;
        tick_to(1000);
        check("rw_late_no_rv", rv_cnt - snap_rv, 0);
        check("rw_late_data", result_data, 0);
        check("rw_idle_no_den", den_cnt - snap_den, 0);
        read_txn(2, 16'h7770, 7'h1B, 2'd0, 1008, "rw_next");
        check("rw_next_done", scan_done, 1);
        check("rw_no_ovr", overrun_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_drp_scanner.md
XADC_DRP_SCANNER -- requirements
Module: xadc_drp_scanner

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, meaning scan period in clock cycles (1 kHz at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles per DRP read before it is abandoned.
REQ-003 The block SHALL have input port CLK100MHZ, 1 bit: the single system clock; all logic on rising edge.
REQ-004 The block SHALL have input port reset, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input port ch_addr_list, 28 bits: four 7-bit DRP addresses; slot k at bits [7k+6:7k].
REQ-006 The block SHALL have input port ch_enable, 4 bits: per-slot scan enable.
REQ-007 The block SHALL have output port daddr_out, 7 bits: DRP address to the XADC.
REQ-008 The block SHALL have output port den_out, 1 bit: DRP enable, single-cycle pulse.
REQ-009 The block SHALL have output port dwe_out, 1 bit: DRP write enable, tied 0 (read-only controller).
REQ-010 The block SHALL have input port do_in, 16 bits: DRP read data.
REQ-011 The block SHALL have input port drdy_in, 1 bit: DRP data ready.
REQ-012 The block SHALL have input port busy_in, 1 bit: XADC busy.
REQ-013 The block SHALL have output port result_data, 12 bits: latest conversion, do_in[15:4].
REQ-014 The block SHALL have output port result_slot, 2 bits: slot index of result_data.
REQ-015 The block SHALL have output port result_valid, 1 bit: one-cycle strobe qualifying result_data and result_slot.
REQ-016 The block SHALL have output port scan_done, 1 bit: one-cycle strobe at the end of each scan.
REQ-017 The block SHALL have output port timeout_err, 1 bit: sticky, set on any DRP read timeout.
REQ-018 The block SHALL have output port overrun_err, 1 bit: sticky, set when a tick arrives while a scan is active.

Function
REQ-019 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick asserts for one cycle when count == TICK_DIV-1.
REQ-020 The FSM SHALL use states IDLE, ISSUE, WAIT, STORE, NEXT.
REQ-021 IDLE: on tick with ch_enable != 0, the FSM SHALL latch ch_enable into en_q, set idx to the lowest set bit of en_q, and go to ISSUE.
REQ-022 IDLE: on tick with ch_enable == 0, the FSM SHALL stay in IDLE with no strobes.
REQ-023 ISSUE: while busy_in is 1, the FSM SHALL hold with den_out = 0.
REQ-024 ISSUE: with busy_in = 0, the FSM SHALL drive den_out = 1 for exactly one cycle with daddr_out = slot idx address, clear the timeout counter, and go to WAIT.
REQ-025 daddr_out SHALL hold its value from ISSUE until the next ISSUE.
REQ-026 WAIT: on drdy_in = 1, the FSM SHALL register do_in[15:4] into result_data and idx into result_slot, then go to STORE.
REQ-027 WAIT: drdy_in SHALL take priority over timeout when both occur in the same cycle.
REQ-028 WAIT: when the counter reaches TIMEOUT without drdy_in, the FSM SHALL set timeout_err, leave result_data unchanged, emit no result_valid, and go to NEXT.
REQ-029 STORE: result_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL go to NEXT.
REQ-030 Latency from the den_out pulse to result_valid SHALL be (cycles until drdy_in) + 2.
REQ-031 NEXT: if en_q has a set bit above idx, the FSM SHALL move idx to the next set bit and go to ISSUE; otherwise it SHALL pulse scan_done and go to IDLE.
REQ-032 Changes to ch_enable mid-scan SHALL be ignored until the next scan start; ch_addr_list SHALL be sampled at each ISSUE.
REQ-033 A tick in any state other than IDLE SHALL set overrun_err and be dropped, with no queued restart.
REQ-034 drdy_in outside WAIT SHALL be ignored.
REQ-035 At most one DRP transaction SHALL be outstanding at any time.

Reset
REQ-036 While reset = 1, the block SHALL set state = IDLE, tick counter = 0, idx = 0, en_q = 0, daddr_out = 0, den_out = 0, dwe_out = 0, result_data = 0, result_slot = 0, result_valid = 0, scan_done = 0, timeout_err = 0, and overrun_err = 0.
REQ-037 Reset asserted mid-transaction SHALL abort it without a strobe, and any late drdy_in SHALL be ignored.
REQ-038 timeout_err and overrun_err SHALL clear only on reset.

Verification
REQ-039 The bench SHALL cover: TICK_DIV=100, ch_enable=4'b0101, addrs slot0=0x1B, slot2=0x13, drdy 3 cycles after den -> two den pulses (0x1B then 0x13), result_valid with slots 0 then 2, then scan_done.
REQ-040 The bench SHALL cover: do_in=16'hFFF0 -> result_data=12'hFFF; do_in=16'h0008 -> result_data=12'h000.
REQ-041 The bench SHALL cover: busy_in held high 10 cycles at ISSUE -> den_out stays 0, then pulses on the first cycle busy_in = 0.
REQ-042 The bench SHALL cover: no drdy_in, TIMEOUT=255 -> timeout_err set, no result_valid, scan continues to the next slot, scan_done still pulses.
REQ-043 The bench SHALL cover: drdy delayed past TICK_DIV -> overrun_err = 1, and exactly one scan_done per started scan.
REQ-044 The bench SHALL cover: reset during WAIT, then drdy_in pulsed -> all outputs 0, no result_valid, FSM in IDLE until the next tick.
